// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM,
// and a one-entry output buffer whose opcode field feeds the control unit.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode,
  output logic            fetch_idle
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            slot_free;
  logic            issue;
  logic            load;

  // Only issue when the buffer is guaranteed free, so a response always has a slot.
  assign slot_free      = !if_valid || if_ready;
  assign imem_req_valid = rst_n && (state == REQ) && slot_free && !redirect_valid;
  assign issue          = imem_req_valid && imem_req_ready;
  assign load           = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign imem_addr      = fetch_pc;
  assign if_opcode      = if_instr[6:0];
  assign fetch_idle     = (state == REQ) && !imem_req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end

      if (issue) begin
        req_pc <= fetch_pc;
      end

      if (load) begin
        if_instr <= imem_rsp_data;
        if_pc    <= req_pc;
      end

      if (redirect_valid) begin
        if_valid <= 1'b0;
      end else if (load) begin
        if_valid <= 1'b1;
      end else if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end

      // Any response retires the single outstanding request, even one arriving with a redirect.
      unique case (state)
        REQ:     if (issue) state <= WAIT;
        WAIT: begin
          if (imem_rsp_valid)      state <= REQ;
          else if (redirect_valid) state <= DRAIN;
        end
        DRAIN:   if (imem_rsp_valid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle vectors for the handshake outputs plus a
// scoreboard of issued requests checked against the buffered instructions.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
  logic        fetch_idle;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode),
    .fetch_idle     (fetch_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        mrdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic        e_idle;
  } vec_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          cnt      = 0;
  logic        pending  = 1'b0;
  logic [31:0] paddr    = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One cycle: drive inputs, sample at negedge, advance memory model after the edge.
  task automatic step(input logic rdy, input logic mrdy, input logic redir, input logic [31:0] rpc,
                      input logic e_req, input logic [31:0] e_addr, input logic e_ifv,
                      input logic e_idle);
    logic        hs;
    logic        rsp_now;
    logic [31:0] ha;
    exp_t        e;
    if_ready       = rdy;
    imem_req_ready = mrdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(negedge clk);
    chk("req_valid", 32'(imem_req_valid), 32'(e_req));
    if (e_req) chk("req_addr", imem_addr, e_addr);
    chk("if_valid", 32'(if_valid), 32'(e_ifv));
    chk("fetch_idle", 32'(fetch_idle), 32'(e_idle));
    chk("rsp_in_idle", 32'(imem_rsp_valid && fetch_idle), 32'd0);
    hs      = imem_req_valid && imem_req_ready;
    ha      = imem_addr;
    rsp_now = imem_rsp_valid;
    if (redir) begin
      q.delete();
    end else if (if_valid && if_ready) begin
      if (q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", if_instr, e.instr);
        chk("if_opcode", 32'(if_opcode), 32'(e.instr[6:0]));
      end
    end else if (if_valid && q.size() > 0) begin
      chk("hold_pc", if_pc, q[0].pc);
      chk("hold_instr", if_instr, q[0].instr);
    end
    if (hs) q.push_back('{pc: ha, instr: mem_word(ha)});
    @(posedge clk);
    #1;
    if (rsp_now) pending = 1'b0;
    if (hs) begin
      pending = 1'b1;
      paddr   = ha;
      cnt     = lat - 1;
    end else if (pending && cnt > 0) begin
      cnt--;
    end
    imem_rsp_valid = pending && (cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(paddr) : 32'hDEAD_BEEF;
    cyc++;
  endtask

  initial begin
    vec_t tbl[14];
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0};
    for (int i = 7; i < 12; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10C, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0};

    rst_n          = 1'b0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_fetch_idle", 32'(fetch_idle), 32'd1);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_opcode", 32'(if_opcode), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Sequential fetch at latency 1, then a 5-cycle downstream stall.
    for (int i = 0; i < 14; i++)
      step(tbl[i].rdy, tbl[i].mrdy, tbl[i].redir, tbl[i].rpc,
           tbl[i].e_req, tbl[i].e_addr, tbl[i].e_ifv, tbl[i].e_idle);

    // Redirect while WAIT, stale response two cycles later.
    lat = 3;
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h110, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0,   1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 1'b0);
    lat = 1;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 1'b0);

    // Redirect coinciding with the response.
    step(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0);

    // Redirect in REQ with a full, stalled buffer.
    step(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0,   1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h404, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0);

    // PC wraparound; target low bits are masked.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    lat = 3;
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    #2 rst_n = 1'b0;
    pending        = 1'b0;
    imem_rsp_valid = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_idle", 32'(fetch_idle), 32'd1);
    chk("mid_rst_if_pc", if_pc, 32'd0);
    chk("mid_rst_opcode", 32'(if_opcode), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lat = 1;
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, RST_PC, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, RST_PC + 32'd4, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
